// File: rtl/aes_pkg.sv
// Shared AES datapath types: word/block widths, word index type and the
// word-packer state encoding.
package aes_pkg;

  localparam int unsigned AES_WORD_W  = 32;
  localparam int unsigned AES_NWORDS  = 4;
  localparam int unsigned AES_BLOCK_W = AES_WORD_W * AES_NWORDS;

  typedef logic [AES_WORD_W-1:0]  aes_word_t;
  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [1:0]             aes_widx_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } packer_state_t;

endpackage

// File: rtl/aes_word_packer.sv
// Packs a word-serial stream (most-significant word first) into 128-bit AES
// blocks, with a one-block output register so filling overlaps draining.
module aes_word_packer
  import aes_pkg::*;
#(
  parameter  int unsigned WORD_W  = 32,
  parameter  int unsigned WORDS   = 4,
  localparam int unsigned BLOCK_W = WORD_W * WORDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic [2:0]         fill_level
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  packer_state_t      state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]  acc_q [WORDS];
  logic [WORD_W-1:0]  acc_d [WORDS];
  logic [BLOCK_W-1:0] out_block_q, out_block_d;
  logic               out_valid_q, out_valid_d;

  logic               out_free;
  logic               in_xfer;
  logic [BLOCK_W-1:0] acc_block;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == FILL) && !clear;
  assign in_xfer  = in_valid && in_ready;

  // Word 0 lands in the most-significant slot of the block.
  always_comb begin
    acc_block = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      acc_block[BLOCK_W-1-i*WORD_W -: WORD_W] = acc_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_block_d = out_block_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // clear never touches the output register; a load below re-asserts out_valid.
    if (clear) begin
      idx_d   = '0;
      state_d = FILL;
    end else begin
      unique case (state_q)
        FILL: begin
          if (in_xfer) begin
            if (idx_q != LAST_IDX) begin
              acc_d[idx_q] = in_word;
              idx_d        = idx_q + IDX_W'(1);
            end else if (out_free) begin
              out_block_d               = acc_block;
              out_block_d[WORD_W-1:0]   = in_word;
              out_valid_d               = 1'b1;
              idx_d                     = '0;
            end else begin
              acc_d[LAST_IDX] = in_word;
              state_d         = FULL;
            end
          end
        end
        FULL: begin
          if (out_free) begin
            out_block_d = acc_block;
            out_valid_d = 1'b1;
            idx_d       = '0;
            state_d     = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      acc_q       <= '{default: '0};
      out_block_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_block_q <= out_block_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_block  = out_block_q;
  assign fill_level = (state_q == FULL) ? 3'(WORDS) : 3'(idx_q);

endmodule

// File: tb/tb_aes_word_packer.sv
// Bench for aes_word_packer: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of accepted words and the output slot.
module tb_aes_word_packer;

  logic         clk = 1'b0;
  logic         rst, clear, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]  in_word;
  logic [127:0] out_block;
  logic [2:0]   fill_level;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // Model: words accepted but not yet moved to the output slot, plus the slot.
  logic [31:0]  pend[$];
  logic         m_ov = 1'b0;
  logic [127:0] m_ob = '0;

  aes_word_packer #(.WORD_W(32), .WORDS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [127:0] pend_block();
    return {pend[0], pend[1], pend[2], pend[3]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic v, input logic o,
                      input logic [31:0] w);
    logic out_free;
    rst = r; clear = c; in_valid = v; out_ready = o; in_word = w;
    #1;
    chk("in_ready", {127'd0, in_ready}, {127'd0, (pend.size() < 4) && !c});
    @(posedge clk);
    if (r) begin
      pend.delete();
      m_ov = 1'b0;
      m_ob = '0;
    end else begin
      out_free = !m_ov || o;
      if (m_ov && o) m_ov = 1'b0;
      if (c) begin
        pend.delete();
      end else if (pend.size() == 4) begin
        if (out_free) begin
          m_ob = pend_block(); m_ov = 1'b1; pend.delete();
        end
      end else if (v) begin
        pend.push_back(w);
        if (pend.size() == 4 && out_free) begin
          m_ob = pend_block(); m_ov = 1'b1; pend.delete();
        end
      end
    end
    #1;
    chk("out_valid", {127'd0, out_valid}, {127'd0, m_ov});
    chk("out_block", out_block, m_ob);
    chk("fill_level", {125'd0, fill_level}, 128'(pend.size()));
  endtask

  logic [31:0] wa [8];

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_word = 'x;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_block", out_block, 128'd0);
    chk("rst_fill", {125'd0, fill_level}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);

    // 1: single block, consumer always ready
    step(0, 0, 1, 1, 32'h00112233);
    step(0, 0, 1, 1, 32'h44556677);
    step(0, 0, 1, 1, 32'h8899aabb);
    step(0, 0, 1, 1, 32'hccddeeff);
    chk("t1_block", out_block, 128'h00112233_44556677_8899aabb_ccddeeff);
    step(0, 0, 0, 1, 'x);

    // 2: eight back-to-back words
    for (int i = 0; i < 8; i++) wa[i] = $urandom;
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, wa[i]);
    chk("t2_block2", out_block, {wa[4], wa[5], wa[6], wa[7]});
    step(0, 0, 0, 1, 'x);

    // 3: consumer stalled for eight words, then released
    for (int i = 0; i < 8; i++) wa[i] = $urandom;
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, wa[i]);
    chk("t3_block1_held", out_block, {wa[0], wa[1], wa[2], wa[3]});
    chk("t3_full_level", {125'd0, fill_level}, 128'd4);
    step(0, 0, 1, 0, 32'hdeadbeef);
    step(0, 0, 0, 1, 'x);
    chk("t3_block2", out_block, {wa[4], wa[5], wa[6], wa[7]});
    step(0, 0, 0, 1, 'x);

    // 4: clear with the third word
    for (int i = 0; i < 7; i++) wa[i] = $urandom;
    step(0, 0, 1, 1, wa[0]);
    step(0, 0, 1, 1, wa[1]);
    step(0, 1, 1, 1, wa[2]);
    chk("t4_level", {125'd0, fill_level}, 128'd0);
    for (int i = 3; i < 7; i++) step(0, 0, 1, 1, wa[i]);
    chk("t4_block", out_block, {wa[3], wa[4], wa[5], wa[6]});

    // 5: reset mid-block while a block is waiting
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, $urandom);
    step(1, 0, 0, 0, 'x);
    chk("t5_out_valid", {127'd0, out_valid}, 128'd0);
    chk("t5_out_block", out_block, 128'd0);
    step(0, 0, 0, 0, 'x);

    // 6: clear while FULL
    for (int i = 0; i < 8; i++) wa[i] = $urandom;
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, wa[i]);
    step(0, 1, 1, 0, 32'h12345678);
    chk("t6_block_kept", out_block, {wa[0], wa[1], wa[2], wa[3]});
    chk("t6_valid_kept", {127'd0, out_valid}, 128'd1);
    step(0, 0, 0, 1, 'x);

    // random traffic, with X on in_word whenever it is not offered
    for (int i = 0; i < 400; i++) begin
      logic v;
      v = ($urandom % 4) != 0;
      step(($urandom % 80) == 0, ($urandom % 25) == 0, v, ($urandom % 3) != 0,
           v ? 32'($urandom) : 'x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
